// File: rtl/pipe2_acc.sv
// Three-stage multiply-accumulate: register F/E, register F*E, then sum N valid
// products into a windowed result G with a saturation flag and a completion pulse.
module pipe2_acc #(
  parameter int WIDTH = 10,
  parameter int ACC_W = 24,
  parameter int N     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [0:WIDTH-1] F,
  input  logic [0:WIDTH-1] E,
  input  logic             in_valid,
  input  logic             clear,
  output logic [0:ACC_W-1] G,
  output logic             out_valid,
  output logic             sat,
  output logic [7:0]       cnt
);

  localparam int PROD_W = 2 * WIDTH;
  localparam logic [7:0] LAST_IDX = 8'(N - 1);

  // Stage 1: captured sample
  logic [WIDTH-1:0]  s1_f_q, s1_f_d;
  logic [WIDTH-1:0]  s1_e_q, s1_e_d;
  logic              s1_v_q, s1_v_d;
  // Stage 2: full-width product
  logic [PROD_W-1:0] prod_q, prod_d;
  logic              s2_v_q, s2_v_d;
  // Stage 3: window accumulator and reported result
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic [ACC_W-1:0]  g_q, g_d;
  logic              sat_q, sat_d;
  logic              out_valid_q, out_valid_d;

  logic [ACC_W:0]    sum_ext;
  logic              add_sat;
  logic [ACC_W-1:0]  sum_clamped;
  logic              win_done;

  // One carry bit is enough: acc and prod are each at most 2^ACC_W-1.
  assign sum_ext     = (ACC_W+1)'(acc_q) + (ACC_W+1)'(prod_q);
  assign add_sat     = sum_ext[ACC_W];
  assign sum_clamped = add_sat ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
  assign win_done    = (cnt_q == LAST_IDX);

  // NOTE: every _d gets a default before any branch so no latch is inferred.
  always_comb begin
    s1_f_d      = F;
    s1_e_d      = E;
    s1_v_d      = in_valid;
    prod_d      = PROD_W'(s1_f_q) * PROD_W'(s1_e_q);
    s2_v_d      = s1_v_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    g_d         = g_q;
    sat_d       = sat_q;
    out_valid_d = 1'b0;

    if (clear) begin
      // Flush wins over a window completing in the same cycle; G/sat keep their value.
      s1_v_d = 1'b0;
      s2_v_d = 1'b0;
      acc_d  = '0;
      cnt_d  = '0;
      ovf_d  = 1'b0;
    end else if (s2_v_q) begin
      if (win_done) begin
        g_d         = sum_clamped;
        sat_d       = ovf_q | add_sat;
        out_valid_d = 1'b1;
        acc_d       = '0;
        cnt_d       = '0;
        ovf_d       = 1'b0;
      end else begin
        acc_d = sum_clamped;
        cnt_d = cnt_q + 8'd1;
        ovf_d = ovf_q | add_sat;
      end
    end
  end

  // NOTE: only control and visible state need reset; data registers are
  // qualified by the stage valids, so leaving them unreset is safe.
  always_ff @(posedge clk) begin
    s1_f_q <= s1_f_d;
    s1_e_q <= s1_e_d;
    prod_q <= prod_d;
  end

  // NOTE: non-blocking assignments for all state so every register samples
  // the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_q      <= 1'b0;
      s2_v_q      <= 1'b0;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      g_q         <= '0;
      sat_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      s1_v_q      <= s1_v_d;
      s2_v_q      <= s2_v_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      g_q         <= g_d;
      sat_q       <= sat_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign G         = g_q;
  assign sat       = sat_q;
  assign out_valid = out_valid_q;
  assign cnt       = cnt_q;

endmodule

// File: tb/tb_pipe2_acc.sv
// Directed bench for pipe2_acc: three instances (N=4/ACC_W=24, N=2/ACC_W=20,
// N=3) share one stimulus stream; each test checks the instance it targets.
module tb_pipe2_acc;

  logic       clk = 1'b0;
  logic       rst;
  logic [0:9] f, e;
  logic       in_valid, clear;

  logic [0:23] g_a;  logic ov_a, sat_a;  logic [7:0] cnt_a;
  logic [0:19] g_s;  logic ov_s, sat_s;  logic [7:0] cnt_s;
  logic [0:23] g_3;  logic ov_3, sat_3;  logic [7:0] cnt_3;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipe2_acc #(.WIDTH(10), .ACC_W(24), .N(4)) u_a (
    .clk(clk), .rst(rst), .F(f), .E(e), .in_valid(in_valid), .clear(clear),
    .G(g_a), .out_valid(ov_a), .sat(sat_a), .cnt(cnt_a));

  pipe2_acc #(.WIDTH(10), .ACC_W(20), .N(2)) u_s (
    .clk(clk), .rst(rst), .F(f), .E(e), .in_valid(in_valid), .clear(clear),
    .G(g_s), .out_valid(ov_s), .sat(sat_s), .cnt(cnt_s));

  pipe2_acc #(.WIDTH(10), .ACC_W(24), .N(3)) u_3 (
    .clk(clk), .rst(rst), .F(f), .E(e), .in_valid(in_valid), .clear(clear),
    .G(g_3), .out_valid(ov_3), .sat(sat_3), .cnt(cnt_3));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Apply inputs, let one rising edge consume them, settle 1 time unit.
  task automatic send(input int fv, input int ev, input logic v, input logic c);
    f = 10'(fv); e = 10'(ev); in_valid = v; clear = c;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    send(0, 0, 1'b0, 1'b0);
    send(0, 0, 1'b0, 1'b0);
    rst = 1'b0;
  endtask

  initial begin
    int pulses;
    int bf[9];
    logic bv[9];
    int bc[9];
    int cf[9];
    logic cv[9];
    logic cc[9];

    rst = 1'b1; f = '0; e = '0; in_valid = 1'b0; clear = 1'b0;
    do_reset();
    check("rst_g_a",   32'(g_a),   0);
    check("rst_ov_a",  32'(ov_a),  0);
    check("rst_sat_a", 32'(sat_a), 0);
    check("rst_cnt_a", 32'(cnt_a), 0);
    check("rst_g_s",   32'(g_s),   0);
    check("rst_cnt_3", 32'(cnt_3), 0);

    // Basic window, E=1: 120+100+220+5 = 445, cnt steps 1,2,3,0
    send(120, 1, 1'b1, 1'b0); check("basic_cnt_t0", 32'(cnt_a), 0);
    send(100, 1, 1'b1, 1'b0); check("basic_cnt_t1", 32'(cnt_a), 0);
    send(220, 1, 1'b1, 1'b0); check("basic_cnt_t2", 32'(cnt_a), 1);
    send(5,   1, 1'b1, 1'b0); check("basic_cnt_t3", 32'(cnt_a), 2);
    send(0,   0, 1'b0, 1'b0); check("basic_cnt_t4", 32'(cnt_a), 3);
                              check("basic_ov_early", 32'(ov_a), 0);
    send(0,   0, 1'b0, 1'b0); check("basic_ov", 32'(ov_a), 1);
                              check("basic_g", 32'(g_a), 445);
                              check("basic_sat", 32'(sat_a), 0);
                              check("basic_cnt_t5", 32'(cnt_a), 0);
    send(0,   0, 1'b0, 1'b0); check("basic_ov_pulse", 32'(ov_a), 0);
                              check("basic_g_hold", 32'(g_a), 445);

    // Multiply path: 120 + 100 + 220 + 5 = 445
    do_reset();
    check("mul_g_rst", 32'(g_a), 0);
    send(10, 12, 1'b1, 1'b0);
    send(10, 10, 1'b1, 1'b0);
    send(20, 11, 1'b1, 1'b0);
    send(1,  5,  1'b1, 1'b0);
    send(0,  0,  1'b0, 1'b0); check("mul_ov_early", 32'(ov_a), 0);
    send(0,  0,  1'b0, 1'b0); check("mul_ov", 32'(ov_a), 1);
                              check("mul_g", 32'(g_a), 445);

    // Windowing: 4 x 1046529 = 4186116 on u_a; u_s (ACC_W=20, N=2) saturates
    do_reset();
    send(1023, 1023, 1'b1, 1'b0);
    send(1023, 1023, 1'b1, 1'b0);
    send(1023, 1023, 1'b1, 1'b0);
    send(1023, 1023, 1'b1, 1'b0);
    check("sat_ov_s_w1",  32'(ov_s),  1);
    check("sat_g_s_w1",   32'(g_s),   1048575);
    check("sat_sat_s_w1", 32'(sat_s), 1);
    send(0, 0, 1'b0, 1'b0);
    send(0, 0, 1'b0, 1'b0);
    check("big_ov_a",  32'(ov_a),  1);
    check("big_g_a",   32'(g_a),   4186116);
    check("big_sat_a", 32'(sat_a), 0);
    check("sat_ov_s_w2",  32'(ov_s),  1);
    check("sat_sat_s_w2", 32'(sat_s), 1);
    send(1, 1, 1'b1, 1'b0);
    send(1, 1, 1'b1, 1'b0);
    send(0, 0, 1'b0, 1'b0);
    check("sat_g_s_hold",   32'(g_s),   1048575);
    check("sat_sat_s_hold", 32'(sat_s), 1);
    send(0, 0, 1'b0, 1'b0);
    check("small_ov_s",  32'(ov_s),  1);
    check("small_g_s",   32'(g_s),   2);
    check("small_sat_s", 32'(sat_s), 0);

    // Bubbles on u_3 (N=3): 7, 8, 9 with two idle cycles between
    do_reset();
    bf = '{7, 0, 0, 8, 0, 0, 9, 0, 0};
    bv = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    bc = '{0, 0, 1, 1, 1, 2, 2, 2, 0};
    pulses = 0;
    for (int i = 0; i < 9; i++) begin
      send(bf[i], 1, bv[i], 1'b0);
      check($sformatf("bub_cnt_t%0d", i), 32'(cnt_3), 32'(bc[i]));
      if (ov_3) pulses++;
    end
    check("bub_pulses", 32'(pulses), 1);
    check("bub_g", 32'(g_3), 24);

    // Clear: establish G=12, then flush two in-flight samples plus a third
    do_reset();
    for (int i = 0; i < 4; i++) send(3, 1, 1'b1, 1'b0);
    send(0, 0, 1'b0, 1'b0);
    send(0, 0, 1'b0, 1'b0);
    check("clr_pre_g", 32'(g_a), 12);
    cf = '{50, 50, 50, 1, 2, 3, 4, 0, 0};
    cv = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    cc = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    pulses = 0;
    for (int i = 0; i < 9; i++) begin
      send(cf[i], 1, cv[i], cc[i]);
      if (ov_a) pulses++;
      if (i < 8) check($sformatf("clr_g_hold_t%0d", i), 32'(g_a), 12);
      if (i == 2) check("clr_cnt_flushed", 32'(cnt_a), 0);
      if (i == 5) check("clr_cnt_restart", 32'(cnt_a), 1);
    end
    check("clr_pulses", 32'(pulses), 1);
    check("clr_g", 32'(g_a), 10);

    // Reset mid-window: in-flight samples are lost
    send(5, 1, 1'b1, 1'b0);
    send(5, 1, 1'b1, 1'b0);
    send(5, 1, 1'b1, 1'b0);
    rst = 1'b1;
    send(0, 0, 1'b0, 1'b0);
    rst = 1'b0;
    check("mrst_g",   32'(g_a),   0);
    check("mrst_ov",  32'(ov_a),  0);
    check("mrst_sat", 32'(sat_a), 0);
    check("mrst_cnt", 32'(cnt_a), 0);
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      send(5, 1, (i < 4), 1'b0);
      if (ov_a) pulses++;
    end
    check("mrst_pulses", 32'(pulses), 1);
    check("mrst_g_new", 32'(g_a), 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
